// File: rtl/arith_pkg.sv
// Shared opcode, command and output-slot types for the arithmetic issue stage.
package arith_pkg;

  localparam int CMD_W = 32;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } arith_op_e;

  typedef struct packed {
    logic [CMD_W-1:0] a;
    logic [CMD_W-1:0] b;
    arith_op_e        sel;
  } arith_cmd_t;

  localparam logic [CMD_W-1:0] DIV0_RESULT = {CMD_W{1'b1}};

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/arith_cmd_fifo.sv
// Circular command buffer; the head entry reads as zero while the buffer is empty.
module arith_cmd_fifo import arith_pkg::*; #(
  parameter int DW    = 66,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == {CW{1'b0}});
  assign rdata_o = empty_o ? {DW{1'b0}} : mem_q[rd_ptr_q];

  // Pointer and occupancy next-state; power-of-two depth lets pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_i && !pop_i) begin
      count_d = count_q + CW'(1);
    end else if (pop_i && !push_i) begin
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are never observed while empty, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

endmodule

// File: rtl/arith_issue_stage.sv
// Issue stage: buffers ALU commands, presents the head to an external ALU and
// registers each result into a handshaked output slot.
module arith_issue_stage import arith_pkg::*; #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic [1:0]   in_sel,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_sel,
  input  logic [W-1:0] alu_r,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_r,
  output logic [1:0]   out_sel,
  output logic         out_div0,
  output logic [31:0]  op_count
);

  localparam int DW = 2 * W + 2;

  logic          push_s, pop_s, slot_free_s, fifo_full_s, fifo_empty_s, consume_s;
  logic [DW-1:0] head_s;
  slot_state_e   slot_q, slot_d;
  logic [W-1:0]  out_r_q, out_r_d;
  logic [1:0]    out_sel_q, out_sel_d;
  logic          out_div0_q, out_div0_d;
  logic [31:0]   op_count_q, op_count_d;

  // in_ready depends only on FIFO occupancy, never on out_ready.
  assign in_ready    = !fifo_full_s;
  assign push_s      = in_valid && in_ready;
  assign out_valid   = (slot_q == SLOT_FULL);
  assign consume_s   = out_valid && out_ready;
  assign slot_free_s = !out_valid || out_ready;
  assign pop_s       = !fifo_empty_s && slot_free_s;
  assign {alu_a, alu_b, alu_sel} = head_s;

  assign out_r    = out_r_q;
  assign out_sel  = out_sel_q;
  assign out_div0 = out_div0_q;
  assign op_count = op_count_q;

  arith_cmd_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_s),
    .wdata_i ({in_a, in_b, in_sel}),
    .pop_i   (pop_s),
    .rdata_o (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Output slot next-state: capture the head result whenever the slot can accept it.
  always_comb begin
    slot_d     = slot_q;
    out_r_d    = out_r_q;
    out_sel_d  = out_sel_q;
    out_div0_d = out_div0_q;
    op_count_d = op_count_q;
    case (slot_q)
      SLOT_EMPTY, SLOT_FULL: begin
        if (pop_s) begin
          slot_d     = SLOT_FULL;
          out_r_d    = alu_r;
          out_sel_d  = alu_sel;
          out_div0_d = (alu_sel == OP_DIV) && (alu_b == {W{1'b0}});
        end else if (consume_s) begin
          slot_d = SLOT_EMPTY;
        end else begin
          slot_d = slot_q;
        end
      end
      default: slot_d = SLOT_EMPTY;
    endcase
    if (consume_s) begin
      op_count_d = op_count_q + 32'd1;
    end else begin
      op_count_d = op_count_q;
    end
  end

  // Output slot and completion counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q     <= SLOT_EMPTY;
      out_r_q    <= {W{1'b0}};
      out_sel_q  <= 2'd0;
      out_div0_q <= 1'b0;
      op_count_q <= 32'd0;
    end else begin
      slot_q     <= slot_d;
      out_r_q    <= out_r_d;
      out_sel_q  <= out_sel_d;
      out_div0_q <= out_div0_d;
      op_count_q <= op_count_d;
    end
  end

endmodule
